// File: rtl/multi_player_clock.sv
`default_nettype none
// ============================================================================
// multi_player_clock : N-player game clock with prescaled per-player countdown,
//                      Fischer increment and direct flag-fall loser report.
// Revision: 1.0 - initial release
// ============================================================================
module multi_player_clock #(
  parameter int N_PLAYERS = 2,
  parameter int TIME_W    = 16,
  parameter int TICK_DIV  = 1000,
  parameter int INIT_TIME = 300,
  parameter int INCREMENT = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_restart,
  input  logic                         i_pause,
  input  logic [N_PLAYERS-1:0]         i_move,
  output logic [N_PLAYERS-1:0]         o_active,
  output logic [N_PLAYERS-1:0]         o_loser,
  output logic [N_PLAYERS*TIME_W-1:0]  o_time,
  output logic [2:0]                   o_state,
  output logic                         o_restart
);

  localparam int                c_AW    = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam int                c_PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PW-1:0]   c_PLAST = c_PW'(TICK_DIV - 1);
  localparam logic [c_AW-1:0]   c_ALAST = c_AW'(N_PLAYERS - 1);
  localparam logic [TIME_W-1:0] c_INIT  = TIME_W'(INIT_TIME);
  localparam logic [TIME_W:0]   c_INC   = (TIME_W + 1)'(INCREMENT);
  localparam logic [TIME_W-1:0] c_TMAX  = '1;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t              r_state;
  logic [TIME_W-1:0]   r_time [N_PLAYERS];
  logic [c_PW-1:0]     r_presc;
  logic [c_AW-1:0]     r_active;
  logic [N_PLAYERS-1:0] r_loser;

  logic                w_go_start;
  logic                w_tick;
  logic [TIME_W-1:0]   w_cur_time;
  logic [TIME_W-1:0]   w_ticked;
  logic [TIME_W:0]     w_sum;
  logic [TIME_W-1:0]   w_moved;
  logic [c_AW-1:0]     w_next_active;
  logic [c_AW-1:0]     w_first;
  logic [N_PLAYERS-1:0] w_active_oh;

  // Restart wins in every live state; unknown encodings also fall back to START.
  always_comb begin
    w_go_start = 1'b0;
    case (r_state)
      ST_START:                          w_go_start = 1'b0;
      ST_IDLE, ST_RUN, ST_PAUSE, ST_OVER: w_go_start = i_restart;
      default:                           w_go_start = 1'b1;
    endcase
  end

  always_comb begin
    w_cur_time    = r_time[r_active];
    w_tick        = (r_presc == c_PLAST);
    w_ticked      = (w_tick && (w_cur_time != '0)) ? w_cur_time - TIME_W'(1) : w_cur_time;
    w_sum         = {1'b0, w_ticked} + c_INC;
    w_moved       = w_sum[TIME_W] ? c_TMAX : w_sum[TIME_W-1:0];
    w_next_active = (r_active == c_ALAST) ? '0 : r_active + c_AW'(1);
    w_active_oh   = '0;
    w_active_oh[r_active] = 1'b1;
    w_first       = '0;
    for (int p = N_PLAYERS - 1; p >= 0; p--) begin
      if (i_move[p]) w_first = c_AW'(p);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_START;
      for (int p = 0; p < N_PLAYERS; p++) r_time[p] <= c_INIT;
      r_presc  <= '0;
      r_active <= '0;
      r_loser  <= '0;
    end else if (w_go_start || (r_state == ST_START)) begin
      // Reloading on the way into START as well makes a restart show fresh times at once.
      r_state  <= (r_state == ST_START) ? ST_IDLE : ST_START;
      for (int p = 0; p < N_PLAYERS; p++) r_time[p] <= c_INIT;
      r_presc  <= '0;
      r_active <= '0;
      r_loser  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|i_move) begin
            r_active <= w_first;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_pause) begin
            r_state <= ST_PAUSE;
          end else if (w_cur_time == '0) begin
            r_state <= ST_OVER;
            r_loser <= w_active_oh;
          end else begin
            r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
            if (i_move[r_active]) begin
              r_time[r_active] <= w_moved;
              r_active         <= w_next_active;
            end else begin
              r_time[r_active] <= w_ticked;
            end
          end
        end
        ST_PAUSE: begin
          if (i_pause) r_state <= ST_RUN;
        end
        ST_OVER:  r_state <= ST_OVER;
        default:  r_state <= ST_START;
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_restart = (r_state == ST_START);
  assign o_active  = (r_state == ST_RUN) ? w_active_oh : '0;
  assign o_loser   = r_loser;

  genvar gp;
  generate
    for (gp = 0; gp < N_PLAYERS; gp++) begin : g_time
      assign o_time[gp*TIME_W +: TIME_W] = r_time[gp];
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/multi_player_clock.md
Name: multi_player_clock

Overview:
- Parametrised N-player game clock: successor to the two-player chess clock FSM.
- Generalises player count and integrates per-player countdown timers, a tick prescaler and a Fischer increment.
- Reports the flag-fall loser directly, with no external counters needed.
- Sits between debounced button pulses and the display/score logic.

Parameters:
N_PLAYERS, 2, number of players (2..8); turn order is 0,1,...,N_PLAYERS-1,0,...
TIME_W, 16, width of each player's time counter in time units
TICK_DIV, 1000, i_clk cycles per time unit (>=1)
INIT_TIME, 300, time loaded into every player at START (1..2**TIME_W-1)
INCREMENT, 0, time units added to the mover on each accepted move (0..2**TIME_W-1)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_restart  in  1  single-cycle pulse: abandon game, reload all clocks
i_pause  in  1  single-cycle pulse: toggle RUN<->PAUSE
i_move  in  N_PLAYERS  single-cycle pulses, one bit per player button
o_active  out  N_PLAYERS  one-hot, the player whose clock is running; 0 when no clock runs
o_loser  out  N_PLAYERS  one-hot, the player whose flag fell; valid in OVER, else 0
o_time  out  N_PLAYERS*TIME_W  player p time at bits [p*TIME_W +: TIME_W]
o_state  out  3  START=0, IDLE=1, RUN=2, PAUSE=3, OVER=4
o_restart  out  1  high while in START

Behaviour:
- Reset (async assert, sync use on i_clk):
  - state=START, all times=INIT_TIME, prescaler=0, active index=0.
  - o_active=0, o_loser=0, o_restart=1.
- START: lasts exactly one cycle.
  - Loads all times with INIT_TIME, clears prescaler and loser.
  - Goes to IDLE unconditionally; all inputs are ignored.
- IDLE: no clock runs.
  - If any i_move bit is set, go to RUN with active = lowest set index.
  - i_pause is ignored. i_restart goes to START.
- RUN: priority is i_restart > i_pause > flag-fall > move.
  - i_restart: go to START.
  - i_pause: go to PAUSE. The prescaler holds its value; no tick or move takes effect that cycle.
  - Flag-fall: registered time[active]==0 goes to OVER with o_loser=onehot(active).
  - Move: i_move[active] advances active to (active+1) mod N_PLAYERS and adds INCREMENT to the mover's time.
  - Bits of i_move for non-active players are ignored.
- Prescaler (RUN only):
  - Counts 0..TICK_DIV-1. On the wrap cycle it issues a tick, which decrements time[active].
  - The prescaler does not reset on a move; a turn inherits the partial unit.
  - Decrement saturates at 0.
- Tick and move in the same cycle (time>0):
  - Mover's new time = time-1+INCREMENT, saturating at 2**TIME_W-1.
  - The move is accepted even if time-1 is 0.
- Increment without tick: time+INCREMENT, saturating at 2**TIME_W-1.
- Flag-fall latency:
  - The cycle the decrement makes time 0, the state stays RUN.
  - The next cycle, the state goes to OVER unless restart/pause is present.
  - A move in that next cycle loses to the flag-fall.
- PAUSE:
  - i_restart goes to START; i_pause goes to RUN with the same active player and prescaler value.
  - i_move is ignored. o_active=0.
- OVER:
  - Only i_restart leaves (to START). o_loser is held and times are frozen.
  - o_active=0.
- Illegal state encodings go to START next cycle.
- Reset mid-game: async return to the reset values listed above, regardless of state.
- o_active = onehot(active) only in RUN. All outputs are registered or decoded from registered state; there is no combinational input-to-output path.

Test Plan:
(All scenarios use N_PLAYERS=3, TIME_W=8, TICK_DIV=4, INIT_TIME=5, INCREMENT=2.)
- Reset, then release i_rst_n:
  - o_restart=1 for 1 cycle and all o_time=5.
  - o_state=IDLE next cycle, o_active=0.
- IDLE, pulse i_move=3'b110:
  - RUN, o_active=3'b010.
  - After 4 cycles, time1=4; other times stay 5.
- RUN with active=1, pulse i_move[1] off-tick:
  - time1 +2 (4->6), o_active=3'b100.
  - A simultaneous pulse of i_move[0] has no effect.
- Pause mid-prescaler (count=2), hold 10 cycles, unpause:
  - No time change while paused, o_active=0.
  - After unpause, the first tick arrives 2 cycles later (count resumes at 2).
- Let player 2 run out from 5:
  - time2 reaches 0 after 20 cycles; the next cycle gives o_state=OVER, o_loser=3'b100.
  - i_move ignored; i_restart gives START with all times=5.
- Tick and move on the same cycle with time0=1:
  - time0 becomes 2 and the turn passes to player 1, with no flag-fall.
  - Separately, assert i_rst_n low mid-RUN: immediate START outputs without waiting for a clock edge.
